// File: rtl/fmul_pipe.sv
// IEEE-754 single-precision multiplier with valid/ready handshake, tag sideband and NSTAGE-deep freezeable pipe.
// Optional FMUL_PIPE_NAN_EN enables NaN/infinity handling; otherwise exp 255 is an ordinary exponent.
module fmul_pipe #(
  parameter int NSTAGE = 2,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     x1,
  input  logic [31:0]     x2,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     y,
  output logic            ovf,
  output logic [TAGW-1:0] out_tag
);

  typedef struct packed {
    logic [31:0]     y;
    logic            ovf;
    logic [TAGW-1:0] tag;
  } res_t;

  logic               adv;
  res_t               res_d;
  res_t               pipe_d [NSTAGE];
  res_t               pipe_q [NSTAGE];
  logic [NSTAGE-1:0]  vld_d, vld_q;
  logic [NSTAGE:0]    vld_pipe;

  logic               sgn, z1, z2;
  logic [7:0]         e1, e2;
  logic [23:0]        m1, m2;
  logic [47:0]        prod;
  logic signed [10:0] exp_sum, exp_n, exp_r;
  logic [22:0]        mant, frac;
  logic               guard, sticky, rnd;
  logic [24:0]        sig_r;
`ifdef FMUL_PIPE_NAN_EN
  logic               nan1, nan2, inf1, inf2;
`endif

  // Whole pipe advances together; a held output freezes every stage.
  assign adv       = !vld_q[NSTAGE-1] || out_ready;
  assign in_ready  = adv;
  assign vld_pipe  = {vld_q, in_valid};
  assign out_valid = vld_q[NSTAGE-1];
  assign y         = pipe_q[NSTAGE-1].y;
  assign ovf       = pipe_q[NSTAGE-1].ovf;
  assign out_tag   = pipe_q[NSTAGE-1].tag;

  always_comb begin
    sgn     = x1[31] ^ x2[31];
    e1      = x1[30:23];
    e2      = x2[30:23];
    z1      = (e1 == 8'd0);
    z2      = (e2 == 8'd0);
    m1      = {1'b1, x1[22:0]};
    m2      = {1'b1, x2[22:0]};
    prod    = {24'd0, m1} * {24'd0, m2};
    exp_sum = $signed({3'b000, e1}) + $signed({3'b000, e2}) - 11'sd127;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp_sum + 11'sd1;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_n  = exp_sum;
    end
    rnd   = guard & (sticky | mant[0]);
    sig_r = {2'b01, mant} + {24'd0, rnd};
    // Rounding carry leaves 1.000..., so the fraction is the shifted-down sum.
    if (sig_r[24]) begin
      exp_r = exp_n + 11'sd1;
      frac  = sig_r[23:1];
    end else begin
      exp_r = exp_n;
      frac  = sig_r[22:0];
    end

    res_d.tag = in_tag;
    res_d.ovf = 1'b0;
    res_d.y   = {sgn, exp_r[7:0], frac};
    if (z1 || z2 || exp_r <= 11'sd0) begin
      res_d.y = {sgn, 31'd0};
    end else if (exp_r >= 11'sd255) begin
      res_d.y   = {sgn, 8'hFF, 23'd0};
      res_d.ovf = 1'b1;
    end
`ifdef FMUL_PIPE_NAN_EN
    nan1 = (e1 == 8'hFF) && (x1[22:0] != 23'd0);
    nan2 = (e2 == 8'hFF) && (x2[22:0] != 23'd0);
    inf1 = (e1 == 8'hFF) && (x1[22:0] == 23'd0);
    inf2 = (e2 == 8'hFF) && (x2[22:0] == 23'd0);
    if (nan1 || nan2 || (inf1 && z2) || (inf2 && z1)) begin
      res_d.y   = 32'h7FC0_0000;
      res_d.ovf = 1'b0;
    end else if (inf1 || inf2) begin
      res_d.y   = {sgn, 8'hFF, 23'd0};
      res_d.ovf = 1'b0;
    end
`endif
  end

  always_comb begin
    vld_d  = adv ? vld_pipe[NSTAGE-1:0] : vld_q;
    pipe_d = pipe_q;
    if (adv) begin
      pipe_d[0] = res_d;
      for (int i = 1; i < NSTAGE; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= '0;
      for (int i = 0; i < NSTAGE; i++) pipe_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      pipe_q <= pipe_d;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe: directed vectors, latency, stall, mid-flight reset and random streams.
module tb_fmul_pipe;
  localparam int NS = 2;
  localparam int TW = 4;

  logic          clk = 0, rstn = 0;
  logic          in_valid = 0, in_ready, out_valid, out_ready = 1, ovf;
  logic [31:0]   x1 = 0, x2 = 0, y;
  logic [TW-1:0] in_tag = 0, out_tag;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [31:0]   a, b;
    logic [TW-1:0] tag;
    logic [32:0]   exp;   // {ovf, y}
  } op_t;

  op_t opq[$];
  op_t sb[$];

  fmul_pipe #(.NSTAGE(NS), .TAGW(TW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .ovf(ovf), .out_tag(out_tag));

  always #5 clk = ~clk;

  // Reference: exact 48-bit product, rounded by remainder comparison.
  function automatic logic [32:0] ref_mul(logic [31:0] a, logic [31:0] b);
    logic s;
    int ea, eb, msb, sh, e;
    longint unsigned p, q, rem, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
`ifdef FMUL_PIPE_NAN_EN
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
        (ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return {1'b0, 32'h7FC00000};
    if (ea == 255 || eb == 255) return {1'b0, s, 8'hFF, 23'd0};
`endif
    if (ea == 0 || eb == 0) return {1'b0, s, 31'd0};
    p    = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    msb  = p[47] ? 47 : 46;
    sh   = msb - 23;
    q    = p >> sh;
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = ea + eb - 127 + (msb - 46);
    if (q == (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
    if (e <= 0) return {1'b0, s, 31'd0};
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    return {1'b0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) v[30:23] = 8'd0;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k < 7) v[30:23] = 8'($urandom_range(60, 194));
    return v;
  endfunction

  // mode 0: always ready; 1: random valid/ready; 2: out_ready low for cycles 4..6
  task automatic run_stream(input int mode, input int budget);
    int cyc = 0;
    bit stall_prev = 0;
    logic [31:0] py;
    logic pov;
    logic [TW-1:0] pt;
    op_t e;
    while ((opq.size() > 0 || sb.size() > 0) && cyc < budget) begin
      @(negedge clk);
      in_valid = (opq.size() > 0) && (mode != 1 || $urandom_range(0, 3) != 0);
      if (opq.size() > 0) begin
        x1 = opq[0].a; x2 = opq[0].b; in_tag = opq[0].tag;
      end
      out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : !(mode == 2 && cyc >= 4 && cyc < 7);
      #1;
      if (stall_prev) begin
        n_cmp++;
        if (out_valid !== 1'b1 || y !== py || ovf !== pov || out_tag !== pt) begin
          n_bad++;
          $display("FAIL stall_hold: got v=%b y=%h ovf=%b tag=%0d want v=1 y=%h ovf=%b tag=%0d",
                   out_valid, y, ovf, out_tag, py, pov, pt);
        end
      end
      if (out_valid && !out_ready) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL stall_in_ready: got %b want 0", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got y=%h tag=%0d want none", y, out_tag);
        end else begin
          e = sb.pop_front();
          if ({ovf, y} !== e.exp || out_tag !== e.tag) begin
            n_bad++;
            $display("FAIL result %h*%h: got y=%h ovf=%b tag=%0d want y=%h ovf=%b tag=%0d",
                     e.a, e.b, y, ovf, out_tag, e.exp[31:0], e.exp[32], e.tag);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(opq.pop_front());
      stall_prev = out_valid && !out_ready;
      py = y; pov = ovf; pt = out_tag;
      cyc++;
    end
    n_cmp++;
    if (opq.size() != 0 || sb.size() != 0) begin
      n_bad++;
      $display("FAIL stream_timeout: got %0d pending want 0", opq.size() + sb.size());
    end
    @(negedge clk);
    in_valid = 0; out_ready = 1;
    opq.delete(); sb.delete();
  endtask

  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t,
                         input logic [32:0] ex);
    op_t o;
    o.a = a; o.b = b; o.tag = t; o.exp = ex;
    opq.push_back(o);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (out_valid !== 0 || y !== 0 || ovf !== 0 || out_tag !== 0 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b y=%h ovf=%b tag=%0d rdy=%b want 0 0 0 0 1",
               out_valid, y, ovf, out_tag, in_ready);
    end
    @(negedge clk); @(negedge clk);
    rstn = 1;
  endtask

  task automatic test_latency();
    int lat = 0;
    @(negedge clk);
    x1 = 32'h3FC00000; x2 = 32'h40000000; in_tag = 4'd5; in_valid = 1; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 1;
    repeat (10) begin
      #1;
      if (out_valid) break;
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != NS || y !== 32'h40400000 || ovf !== 0 || out_tag !== 4'd5) begin
      n_bad++;
      $display("FAIL latency: got lat=%0d y=%h ovf=%b tag=%0d want lat=%0d y=40400000 ovf=0 tag=5",
               lat, y, ovf, out_tag, NS);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    push_op(32'h3FC00000, 32'h40000000, 4'd5, {1'b0, 32'h40400000});
    push_op(32'hBF800000, 32'h3F800000, 4'd1, {1'b0, 32'hBF800000});
    push_op(32'h3F800001, 32'h3F800001, 4'd2, {1'b0, 32'h3F800002});
    push_op(32'h00800000, 32'h00800000, 4'd3, {1'b0, 32'h00000000});
    push_op(32'h7F000000, 32'h7F000000, 4'd4, {1'b1, 32'h7F800000});
`ifdef FMUL_PIPE_NAN_EN
    push_op(32'h7FC00000, 32'h3F800000, 4'd6, {1'b0, 32'h7FC00000});
`else
    push_op(32'h7FC00000, 32'h3F800000, 4'd6, {1'b1, 32'h7F800000});
`endif
    push_op(32'h00400000, 32'h3F800000, 4'd7, {1'b0, 32'h00000000});
    push_op(32'h80000000, 32'h3F800000, 4'd8, {1'b0, 32'h80000000});
    push_op(32'h40000000, 32'h40400000, 4'd9, {1'b0, 32'h40C00000});
    run_stream(0, 100);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      a[30:23] = 8'($urandom_range(100, 150));
      b[30:23] = 8'($urandom_range(100, 150));
      push_op(a, b, TW'(i), ref_mul(a, b));
    end
    run_stream(2, 100);
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    x1 = 32'h3F800000; x2 = 32'h40000000; in_tag = 4'd3; in_valid = 1; out_ready = 0;
    @(negedge clk);
    x2 = 32'h40400000; in_tag = 4'd4;
    @(negedge clk);
    in_valid = 0;
    #2;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL inflight_pre: got v=%b want 1", out_valid);
    end
    rstn = 0;
    #1;
    n_cmp++;
    if (out_valid !== 0 || y !== 0 || ovf !== 0 || out_tag !== 0 || in_ready !== 1) begin
      n_bad++;
      $display("FAIL async_reset: got v=%b y=%h ovf=%b tag=%0d rdy=%b want 0 0 0 0 1",
               out_valid, y, ovf, out_tag, in_ready);
    end
    @(negedge clk);
    rstn = 1; out_ready = 1;
    repeat (6) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 0) begin
        n_bad++;
        $display("FAIL stale_after_reset: got v=1 y=%h want v=0", y);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 4000; i++) begin
      a = rnd_fp(); b = rnd_fp();
      push_op(a, b, TW'($urandom), ref_mul(a, b));
    end
    run_stream(1, 40000);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
